// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through a one-shot TX_DV / TX_DONE handshake.
// Define UART_TX_FIFO_CRLF_EN to expand each 8'h0A into the pair 8'h0D, 8'h0A on the wire.
module uart_tx_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  IN_VALID,
    input  logic [7:0]            IN_BYTE,
    output logic                  IN_READY,
    output logic                  TX_DV,
    output logic [7:0]            TX_BYTE,
    input  logic                  TX_DONE,
    output logic [DEPTH_LOG2:0]   COUNT,
    output logic                  BUSY
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_CNT = DEPTH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2 - 1){1'b0}}, 1'b1};

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;
`ifdef UART_TX_FIFO_CRLF_EN
    localparam logic [1:0] ST_SEND_CR   = 2'd3;
`endif

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [1:0]            state_q, state_d;
    logic [7:0]            tx_byte_q, tx_byte_d;
    logic                  tx_dv_q, tx_dv_d;
    logic                  ready_en_q;
    logic                  push;
    logic                  pop;
    logic [7:0]            head_byte;
`ifdef UART_TX_FIFO_CRLF_EN
    logic                  cr_sent_q, cr_sent_d;
`endif

    // ready_en_q holds IN_READY low through reset and for the edge that releases it
    assign IN_READY  = ready_en_q && (count_q != FULL_CNT);
    assign push      = IN_VALID && IN_READY;
    assign pop       = (state_q == ST_ISSUE);
    assign head_byte = mem[rd_ptr_q];

    assign TX_DV   = tx_dv_q;
    assign TX_BYTE = tx_byte_q;
    assign COUNT   = count_q;
    assign BUSY    = (state_q != ST_IDLE);

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr_q] <= IN_BYTE;
        end
    end

    always_comb begin
        wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        tx_byte_d = tx_byte_q;
        tx_dv_d   = 1'b0;
`ifdef UART_TX_FIFO_CRLF_EN
        cr_sent_d = cr_sent_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
`ifdef UART_TX_FIFO_CRLF_EN
                    // A newline goes out twice: CR first without popping, then LF with the pop
                    if (head_byte == 8'h0A && !cr_sent_q) begin
                        tx_byte_d = 8'h0D;
                        state_d   = ST_SEND_CR;
                    end else begin
                        tx_byte_d = head_byte;
                        state_d   = ST_ISSUE;
                    end
`else
                    tx_byte_d = head_byte;
                    state_d   = ST_ISSUE;
`endif
                end
            end
            ST_ISSUE: begin
                tx_dv_d = 1'b1;
                state_d = ST_WAIT_DONE;
`ifdef UART_TX_FIFO_CRLF_EN
                cr_sent_d = 1'b0;
`endif
            end
`ifdef UART_TX_FIFO_CRLF_EN
            ST_SEND_CR: begin
                tx_dv_d   = 1'b1;
                cr_sent_d = 1'b1;
                state_d   = ST_WAIT_DONE;
            end
`endif
            ST_WAIT_DONE: begin
                if (TX_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= ST_IDLE;
            tx_byte_q  <= 8'h00;
            tx_dv_q    <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            tx_byte_q  <= tx_byte_d;
            tx_dv_q    <= tx_dv_d;
            ready_en_q <= 1'b1;
        end
    end

`ifdef UART_TX_FIFO_CRLF_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cr_sent_q <= 1'b0;
        end else begin
            cr_sent_q <= cr_sent_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo (DEPTH_LOG2 = 4); inputs change and outputs are sampled on
// the falling edge, so every sample reflects the state after the preceding rising edge.
module tb_uart_tx_fifo;

    logic       CLK;
    logic       RST_N;
    logic       IN_VALID;
    logic [7:0] IN_BYTE;
    logic       IN_READY;
    logic       TX_DV;
    logic [7:0] TX_BYTE;
    logic       TX_DONE;
    logic [4:0] COUNT;
    logic       BUSY;

    int vectors = 0;
    int fails   = 0;

    uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .IN_VALID (IN_VALID),
        .IN_BYTE  (IN_BYTE),
        .IN_READY (IN_READY),
        .TX_DV    (TX_DV),
        .TX_BYTE  (TX_BYTE),
        .TX_DONE  (TX_DONE),
        .COUNT    (COUNT),
        .BUSY     (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic pulse_done();
        TX_DONE = 1'b1;
        tick();
        TX_DONE = 1'b0;
    endtask

    // Waits (bounded) for a TX_DV strobe, checks the byte, returns cycles waited
    task automatic wait_dv(input logic [7:0] exp, input string tag, output int n);
        n = 0;
        while (TX_DV !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        chk({tag, "_dv"}, 32'(TX_DV), 32'd1);
        chk({tag, "_byte"}, 32'(TX_BYTE), 32'(exp));
    endtask

    initial begin
        int n;
        RST_N    = 1'b0;
        IN_VALID = 1'b0;
        IN_BYTE  = 8'h00;
        TX_DONE  = 1'b0;
        tick();
        tick();
        chk("rst_dv", 32'(TX_DV), 32'd0);
        chk("rst_byte", 32'(TX_BYTE), 32'h00);
        chk("rst_count", 32'(COUNT), 32'd0);
        chk("rst_ready", 32'(IN_READY), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        RST_N = 1'b1;
        #1;
        chk("rel_ready_pre", 32'(IN_READY), 32'd0);
        tick();
        chk("rel_ready_post", 32'(IN_READY), 32'd1);

        // Single byte with a slow transmitter
        IN_VALID = 1'b1;
        IN_BYTE  = 8'h41;
        tick();
        IN_VALID = 1'b0;
        chk("s_e0_count", 32'(COUNT), 32'd1);
        chk("s_e0_busy", 32'(BUSY), 32'd0);
        tick();
        chk("s_e1_busy", 32'(BUSY), 32'd1);
        chk("s_e1_dv", 32'(TX_DV), 32'd0);
        chk("s_e1_byte", 32'(TX_BYTE), 32'h41);
        tick();
        chk("s_e2_dv", 32'(TX_DV), 32'd1);
        chk("s_e2_count", 32'(COUNT), 32'd0);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("s_hold_dv", 32'(TX_DV), 32'd0);
            chk("s_hold_byte", 32'(TX_BYTE), 32'h41);
        end
        pulse_done();
        chk("s_done_busy", 32'(BUSY), 32'd0);
        chk("s_done_byte", 32'(TX_BYTE), 32'h41);

        // Spurious TX_DONE while idle and empty
        for (int i = 0; i < 2; i++) begin
            pulse_done();
            tick();
            chk("sp_dv", 32'(TX_DV), 32'd0);
            chk("sp_count", 32'(COUNT), 32'd0);
            chk("sp_busy", 32'(BUSY), 32'd0);
        end

        // Park the FSM in WAIT_DONE with 8'h2F so nothing else pops, then fill
        IN_VALID = 1'b1;
        IN_BYTE  = 8'h2F;
        tick();
        IN_VALID = 1'b0;
        wait_dv(8'h2F, "park", n);
        for (int i = 0; i < 16; i++) begin
            IN_VALID = 1'b1;
            IN_BYTE  = 8'h30 + 8'(i);
            chk("fill_ready", 32'(IN_READY), 32'd1);
            tick();
        end
        IN_BYTE = 8'h40;
        chk("full_count", 32'(COUNT), 32'd16);
        chk("full_ready", 32'(IN_READY), 32'd0);
        tick();
        chk("full_17th_count", 32'(COUNT), 32'd16);

        // Pop while full with IN_VALID held: no same-cycle bypass
        pulse_done();
        chk("nb_d_ready", 32'(IN_READY), 32'd0);
        chk("nb_d_count", 32'(COUNT), 32'd16);
        tick();
        chk("nb_iss_ready", 32'(IN_READY), 32'd0);
        chk("nb_iss_byte", 32'(TX_BYTE), 32'h30);
        chk("nb_iss_dv", 32'(TX_DV), 32'd0);
        tick();
        chk("nb_pop_dv", 32'(TX_DV), 32'd1);
        chk("nb_pop_count", 32'(COUNT), 32'd15);
        chk("nb_pop_ready", 32'(IN_READY), 32'd1);
        tick();
        IN_VALID = 1'b0;
        chk("nb_refill_count", 32'(COUNT), 32'd16);
        chk("nb_refill_ready", 32'(IN_READY), 32'd0);

        // Drain in push order, each two edges after TX_DONE
        for (int i = 1; i <= 16; i++) begin
            pulse_done();
            wait_dv(8'h30 + 8'(i), "drain", n);
            chk("drain_lat", 32'(n), 32'd2);
        end
        pulse_done();
        tick();
        chk("drain_busy", 32'(BUSY), 32'd0);
        chk("drain_count", 32'(COUNT), 32'd0);

        // Reset in WAIT_DONE with five bytes queued
        for (int i = 0; i < 6; i++) begin
            IN_VALID = 1'b1;
            IN_BYTE  = 8'h50 + 8'(i);
            tick();
        end
        IN_VALID = 1'b0;
        chk("mr_count", 32'(COUNT), 32'd5);
        chk("mr_busy", 32'(BUSY), 32'd1);
        chk("mr_byte", 32'(TX_BYTE), 32'h50);
        RST_N = 1'b0;
        #1;
        chk("mr_rst_dv", 32'(TX_DV), 32'd0);
        chk("mr_rst_count", 32'(COUNT), 32'd0);
        chk("mr_rst_busy", 32'(BUSY), 32'd0);
        chk("mr_rst_ready", 32'(IN_READY), 32'd0);
        chk("mr_rst_byte", 32'(TX_BYTE), 32'h00);
        tick();
        tick();
        RST_N = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("mr_quiet_dv", 32'(TX_DV), 32'd0);
            chk("mr_quiet_count", 32'(COUNT), 32'd0);
        end

        // Newline handling
        IN_VALID = 1'b1;
        IN_BYTE  = 8'h61;
        tick();
        IN_BYTE  = 8'h0A;
        tick();
        IN_VALID = 1'b0;
        wait_dv(8'h61, "nl_a", n);
        tick();
        tick();
        pulse_done();
`ifdef UART_TX_FIFO_CRLF_EN
        wait_dv(8'h0D, "nl_cr", n);
        chk("nl_cr_count", 32'(COUNT), 32'd1);
        tick();
        pulse_done();
`endif
        wait_dv(8'h0A, "nl_lf", n);
        chk("nl_lf_count", 32'(COUNT), 32'd0);
        pulse_done();
        tick();
        chk("nl_busy", 32'(BUSY), 32'd0);
        chk("nl_dv", 32'(TX_DV), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, FIFO depth = 2**DEPTH_LOG2 bytes (legal range 2..8).
REQ-002 SHALL have port CLK  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port IN_VALID  input  1  producer presents IN_BYTE.
REQ-005 SHALL have port IN_BYTE  input  8  byte to enqueue.
REQ-006 SHALL have port IN_READY  output  1  FIFO can accept; push = IN_VALID & IN_READY at a rising edge.
REQ-007 SHALL have port TX_DV  output  1  one-cycle start strobe to the UART transmitter.
REQ-008 SHALL have port TX_BYTE  output  8  byte for the transmitter; registered.
REQ-009 SHALL have port TX_DONE  input  1  one-cycle pulse from the transmitter at end of stop bit.
REQ-010 SHALL have port COUNT  output  DEPTH_LOG2+1  bytes currently stored.
REQ-011 SHALL have port BUSY  output  1  high whenever the FSM is not IDLE.

Function
REQ-012 SHALL store bytes in a circular buffer with DEPTH_LOG2-bit read/write pointers that wrap modulo depth; full/empty SHALL derive from COUNT, never from pointer equality alone.
REQ-013 SHALL drive IN_READY = (COUNT != depth), combinational from registered COUNT; no bypass: a pop in the same cycle SHALL NOT raise IN_READY while full.
REQ-014 SHALL apply push and pop in the same edge with COUNT unchanged and both pointers advanced.
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT_DONE (plus SEND_CR, see Configuration).
REQ-016 IDLE -> ISSUE on any edge where COUNT != 0; TX_BYTE SHALL load the head byte on that edge.
REQ-017 In ISSUE TX_DV SHALL be high for exactly one cycle; the head byte SHALL be popped on the ISSUE edge; next state WAIT_DONE.
REQ-018 TX_BYTE SHALL remain stable from TX_DV assertion until TX_DONE is seen.
REQ-019 WAIT_DONE -> IDLE on TX_DONE; no second TX_DV SHALL be issued before TX_DONE.
REQ-020 TX_DONE received in IDLE or ISSUE SHALL be ignored.
REQ-021 Latency: byte pushed at edge E0 into an empty FIFO with FSM in IDLE SHALL produce TX_DV high in the cycle after edge E2 (E1 IDLE->ISSUE, E2 assert).
REQ-022 Back-to-back: after TX_DONE, the next queued byte's TX_DV SHALL follow within 2 cycles.
REQ-023 Byte order at TX_BYTE SHALL equal push order; no byte dropped or duplicated.

Reset
REQ-024 RST_N low SHALL immediately force TX_DV=0, TX_BYTE=8'h00, COUNT=0, IN_READY=0, BUSY=0, pointers=0, FSM=IDLE.
REQ-025 IN_READY SHALL rise on the first edge after RST_N deasserts; reset mid-transfer SHALL discard all queued and in-flight bytes without generating TX_DV.

Configuration
REQ-026 Macro UART_TX_FIFO_CRLF_EN SHALL compile in newline expansion.
REQ-027 With UART_TX_FIFO_CRLF_EN defined: head byte 8'h0A SHALL first be sent as 8'h0D (state SEND_CR, no pop), then after TX_DONE sent as 8'h0A (with pop); other bytes unchanged.
REQ-028 Without UART_TX_FIFO_CRLF_EN: SEND_CR SHALL not exist and every byte SHALL pass unmodified.

Verification
REQ-029 Push 8'h41 into idle FIFO, TX_DONE 10 cycles after TX_DV -> one TX_DV pulse, TX_BYTE=8'h41 held until TX_DONE, COUNT 1->0, BUSY low after TX_DONE.
REQ-030 Push 16 bytes 8'h30..8'h3F with DEPTH_LOG2=4, no TX_DONE -> COUNT=16, IN_READY=0; 17th byte not accepted; later TX_DONE pulses drain 8'h30..8'h3F in order.
REQ-031 Full FIFO, IN_VALID held high, pop at edge N -> IN_READY high only after edge N, push accepted the following edge, COUNT returns to 16.
REQ-032 Spurious TX_DONE pulses while IDLE with empty FIFO -> no TX_DV, COUNT stays 0.
REQ-033 Assert RST_N low while WAIT_DONE with 5 queued bytes -> TX_DV=0, COUNT=0 immediately; after release, no TX_DV until a new push.
REQ-034 With UART_TX_FIFO_CRLF_EN, push 8'h61, 8'h0A -> TX_BYTE sequence 8'h61, 8'h0D, 8'h0A; without macro -> 8'h61, 8'h0A.
